// File: rtl/tm1638_keys_pkg.sv
// Shared types and constants for the TM1638 key-scan path.
package tm1638_types;

  typedef logic [7:0] keys_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    DECODE
  } keys_state_t;

  // Command byte 0x42 (read keys) followed by a 4-byte read.
  localparam logic [17:0] CMD_READ_KEYS = {2'b10, 8'h00, 8'h42};

  // Key i (0..3) is bit 0 of byte i; key i+4 is bit 4 of byte i.
  function automatic keys_t decode_keys(input logic [31:0] raw);
    keys_t k;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      k[i]   = raw[8*i];
      k[i+4] = raw[8*i+4];
    end
    return k;
  endfunction

endpackage

// File: rtl/tm1638_keys_debounce.sv
// Debounces successive key-scan samples; publishes a stable vector plus
// one-cycle press/release pulses when a new vector has been seen often enough.
module tm1638_keys_debounce
  import tm1638_types::*;
#(
  parameter int DEBOUNCE_SAMPLES = 3
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  sample_valid,
  input  keys_t sample,
  output keys_t keys,
  output keys_t pressed,
  output keys_t released
);

  localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEBOUNCE_SAMPLES);

  keys_t          candidate;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_next;
  logic           accept;

  // Next agreement count: restart on a new candidate, otherwise saturate.
  always_comb begin
    count_next = count;
    if (sample != candidate) begin
      count_next = CW'(1);
    end else if (count >= COUNT_MAX) begin
      count_next = COUNT_MAX;
    end else begin
      count_next = count + 1'b1;
    end
    accept = sample_valid && (count_next >= COUNT_MAX) && (sample != keys);
  end

  // Candidate/count tracking and registered key outputs; pulses default low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      candidate <= '0;
      count     <= '0;
      keys      <= '0;
      pressed   <= '0;
      released  <= '0;
    end else begin
      pressed  <= '0;
      released <= '0;
      if (sample_valid) begin
        candidate <= sample;
        count     <= count_next;
        if (accept) begin
          keys     <= sample;
          pressed  <= sample & ~keys;
          released <= ~sample & keys;
        end
      end
    end
  end

endmodule

// File: rtl/tm1638_keys.sv
// TM1638 key-scan reader: periodically queues a read-keys command, waits for
// the 4-byte response, decodes 8 keys and hands them to the debouncer.
module tm1638_keys
  import tm1638_types::*;
#(
  parameter int SCAN_CYCLES         = 270_000,
  parameter int DEBOUNCE_SAMPLES    = 3,
  parameter int RESP_TIMEOUT_CYCLES = 200_000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Write_Grant,
  input  logic        i_SPI_FIFO_Full,
  output logic [17:0] o_Data,
  output logic        o_Write,
  input  logic        i_Read_Data_Valid,
  input  logic [63:0] i_Read_Data,
  output logic [7:0]  o_Keys,
  output logic [7:0]  o_Pressed,
  output logic [7:0]  o_Released,
  output logic        o_Timeout
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int TW = (RESP_TIMEOUT_CYCLES > 1) ? $clog2(RESP_TIMEOUT_CYCLES) : 1;

  keys_state_t    state, state_next;
  logic [SW-1:0]  scan_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic           scan_done, tmo_done, can_write;
  logic           write_next, timeout_next;
  logic [17:0]    data_next;
  keys_t          sample;

  // Only the first four response bytes carry key data.
  logic unused_read_hi;
  assign unused_read_hi = ^i_Read_Data[63:32];

  assign scan_done = (scan_cnt == SW'(SCAN_CYCLES - 1));
  assign tmo_done  = (tmo_cnt == TW'(RESP_TIMEOUT_CYCLES - 1));
  assign can_write = i_Write_Grant && !i_SPI_FIFO_Full;

  // State register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a response in the expiry cycle still counts.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (scan_done) state_next = REQ;
      REQ:       if (can_write) state_next = WAIT_RESP;
      WAIT_RESP: begin
        if (i_Read_Data_Valid) state_next = DECODE;
        else if (tmo_done)     state_next = IDLE;
      end
      DECODE:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output decode feeding the registered strobes.
  always_comb begin
    write_next   = (state == REQ) && can_write;
    timeout_next = (state == WAIT_RESP) && !i_Read_Data_Valid && tmo_done;
    data_next    = write_next ? CMD_READ_KEYS : '0;
  end

  // Registered outputs, interval counters and response capture.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Write   <= 1'b0;
      o_Timeout <= 1'b0;
      o_Data    <= '0;
      scan_cnt  <= '0;
      tmo_cnt   <= '0;
      sample    <= '0;
    end else begin
      o_Write   <= write_next;
      o_Timeout <= timeout_next;
      o_Data    <= data_next;
      scan_cnt  <= (state == IDLE && !scan_done) ? scan_cnt + 1'b1 : '0;
      tmo_cnt   <= (state == WAIT_RESP && state_next == WAIT_RESP) ? tmo_cnt + 1'b1 : '0;
      if (state == WAIT_RESP && i_Read_Data_Valid) begin
        sample <= decode_keys(i_Read_Data[31:0]);
      end
    end
  end

  tm1638_keys_debounce #(
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
  ) u_debounce (
    .clk          (i_Clk),
    .rst          (i_Rst),
    .sample_valid (state == DECODE),
    .sample       (sample),
    .keys         (o_Keys),
    .pressed      (o_Pressed),
    .released     (o_Released)
  );

endmodule

// File: tb/tb_tm1638_keys.sv
// Scoreboard bench for tm1638_keys: the stimulus process predicts every
// output event (write, timeout, press/release) and queues it; the monitor
// pops and compares whenever the DUT shows an event.
module tb_tm1638_keys;
  import tm1638_types::*;

  localparam int SCAN = 10;
  localparam int DEB  = 3;
  localparam int TMO  = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        grant = 1'b1;
  logic        full = 1'b0;
  logic        rd_valid = 1'b0;
  logic [63:0] rd_data = '0;
  logic [17:0] o_Data;
  logic        o_Write, o_Timeout;
  logic [7:0]  o_Keys, o_Pressed, o_Released;

  tm1638_keys #(
    .SCAN_CYCLES(SCAN), .DEBOUNCE_SAMPLES(DEB), .RESP_TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Write_Grant(grant), .i_SPI_FIFO_Full(full),
    .o_Data(o_Data), .o_Write(o_Write),
    .i_Read_Data_Valid(rd_valid), .i_Read_Data(rd_data),
    .o_Keys(o_Keys), .o_Pressed(o_Pressed), .o_Released(o_Released),
    .o_Timeout(o_Timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    bit         wr;
    bit         tmo;
    logic [7:0] keys;
    logic [7:0] pr;
    logic [7:0] rl;
  } ev_t;

  ev_t        exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_en = 1'b0;
  logic [7:0] mon_keys = '0;

  // Reference model state: accepted keys and the recent decoded scans.
  logic [7:0] model_keys = '0;
  logic [7:0] hist[$];
  int         x = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop an expected event whenever the DUT shows one.
  always @(negedge clk) begin : monitor
    ev_t e;
    bit  active;
    if (rst) begin
      mon_keys = '0;
    end else if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        e = exp_q.pop_front();
        chk("event_missed_cycle", cyc, e.at);
        mon_keys = e.keys;
      end
      active = o_Write || o_Timeout || (o_Pressed != 0) || (o_Released != 0);
      if (active) begin
        if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
          e = exp_q.pop_front();
          chk("write",    o_Write,    e.wr);
          chk("data",     o_Data,     e.wr ? 32'h20042 : 32'h0);
          chk("timeout",  o_Timeout,  e.tmo);
          chk("pressed",  o_Pressed,  e.pr);
          chk("released", o_Released, e.rl);
          chk("keys",     o_Keys,     e.keys);
          mon_keys = e.keys;
        end else begin
          chk("unexpected_event_cycle", cyc, (exp_q.size() > 0) ? exp_q[0].at : -1);
        end
      end else begin
        chk("idle_data", o_Data, 0);
        chk("keys_steady", o_Keys, mon_keys);
      end
    end
  end

  task automatic to_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ev(input int at, input bit wr, input bit tmo,
                         input logic [7:0] pr, input logic [7:0] rl);
    ev_t e;
    e.at = at; e.wr = wr; e.tmo = tmo; e.keys = model_keys; e.pr = pr; e.rl = rl;
    exp_q.push_back(e);
  endtask

  function automatic logic [7:0] ref_decode(input logic [31:0] d);
    logic [7:0] k;
    for (int i = 0; i < 4; i++) begin
      k[i]     = d[8*i];
      k[i + 4] = d[8*i + 4];
    end
    return k;
  endfunction

  // A vector is accepted once the last DEB scans agree and it differs from the current keys.
  task automatic model_sample(input logic [31:0] d, input int at);
    logic [7:0] dec;
    bit         stable;
    logic [7:0] pr, rl;
    dec = ref_decode(d);
    hist.push_back(dec);
    if (hist.size() > DEB) void'(hist.pop_front());
    stable = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != dec) stable = 1'b0;
    if (stable && dec != model_keys) begin
      pr = dec & ~model_keys;
      rl = ~dec & model_keys;
      model_keys = dec;
      push_ev(at, 1'b0, 1'b0, pr, rl);
    end
  endtask

  // One scan: optional blocking of the write, optional stray valid in IDLE,
  // then a response after lat cycles (lat = 0 withholds it).
  task automatic scan(input int blk, input bit blk_full, input int lat,
                      input logic [31:0] d, input bit stray);
    int w, v;
    if (blk > 0) begin
      if (blk_full) full = 1'b1;
      else          grant = 1'b0;
    end
    w = x + SCAN + 1 + blk;
    push_ev(w, 1'b1, 1'b0, 8'h00, 8'h00);
    if (stray) begin
      to_edge(x + 2);
      rd_valid = 1'b1;
      rd_data  = {$urandom, 32'h11111111};
      to_edge(x + 3);
      rd_valid = 1'b0;
    end
    to_edge(x + SCAN + blk);
    full  = 1'b0;
    grant = 1'b1;
    if (lat == 0) begin
      push_ev(w + TMO, 1'b0, 1'b1, 8'h00, 8'h00);
      x = w + TMO;
      to_edge(x);
    end else begin
      v = w + lat;
      to_edge(v - 1);
      rd_valid = 1'b1;
      rd_data  = {$urandom, d};
      model_sample(d, v + 1);
      to_edge(v);
      rd_valid = 1'b0;
      x = v + 1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_keys"},     o_Keys,     0);
    chk({tag, "_pressed"},  o_Pressed,  0);
    chk({tag, "_released"}, o_Released, 0);
    chk({tag, "_write"},    o_Write,    0);
    chk({tag, "_timeout"},  o_Timeout,  0);
    chk({tag, "_data"},     o_Data,     0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] pool[4];
    logic [31:0] d;
    int          w;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    rst = 1'b0;
    x = cyc;
    mon_en = 1'b1;

    // Press key 0, then move to key 7 (press 7, release 0 together).
    repeat (3) scan(0, 1'b0, 3, 32'h00000001, 1'b0);
    repeat (3) scan(0, 1'b0, 5, 32'h10000000, 1'b0);
    // Alternating scans never settle.
    for (int i = 0; i < 4; i++) scan(0, 1'b0, 2 + i, (i % 2 == 0) ? 32'h1 : 32'h0, 1'b0);
    // Long stalls on FIFO full and on missing grant.
    scan(100, 1'b1, 4, 32'h10000000, 1'b0);
    scan(100, 1'b0, 7, 32'h10000000, 1'b0);
    // Withheld response, then a response in the expiry cycle plus a stray IDLE valid.
    scan(0, 1'b0, 0, 32'h0, 1'b0);
    scan(0, 1'b0, TMO, 32'h10000000, 1'b1);

    // Asynchronous reset while waiting for a response.
    w = x + SCAN + 1;
    push_ev(w, 1'b1, 1'b0, 8'h00, 8'h00);
    to_edge(w + 5);
    chk("keys_before_reset", o_Keys, 8'h80);
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    chk("queue_empty_at_reset", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    x = cyc;
    model_keys = '0;
    hist.delete();
    // Stray valid right after reset must be ignored.
    scan(0, 1'b0, 3, 32'h00000010, 1'b1);

    // Randomised scans.
    pool[0] = 32'h11111111;
    pool[1] = $urandom;
    pool[2] = $urandom;
    pool[3] = 32'h00000000;
    d = pool[0];
    for (int i = 0; i < 45; i++) begin
      int blk, lat;
      blk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
      lat = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TMO);
      if ($urandom_range(0, 2) == 0) d = pool[$urandom_range(0, 3)];
      scan(blk, $urandom_range(0, 1) == 1, lat, d, $urandom_range(0, 4) == 0);
    end

    to_edge(cyc + 5);
    chk("leftover_events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
